// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
//   - Opcode encodings (OP_ADD .. OP_CLC); 13..15 are illegal.
//   - Bit positions inside the 5-bit flags word {gt,v,n,z,c}.
//   - Control FSM state encoding and the shift-kind encoding.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_ADC = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_SBB = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_GT  = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;
    localparam logic [3:0] OP_ASR = 4'd10;
    localparam logic [3:0] OP_ROL = 4'd11;
    localparam logic [3:0] OP_CLC = 4'd12;

    localparam int F_C  = 0;
    localparam int F_Z  = 1;
    localparam int F_N  = 2;
    localparam int F_V  = 3;
    localparam int F_GT = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Matches OPcode[1:0] of the four shift opcodes (8..11).
    typedef enum logic [1:0] {
        SH_SHL = 2'd0,
        SH_SHR = 2'd1,
        SH_ASR = 2'd2,
        SH_ROL = 2'd3
    } shift_e;

    function automatic logic is_shift_op(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/alu_seq_shift.sv
// Serial shift/rotate datapath: moves the work register by one bit position
// per step.
//   clk, rst    : clock, synchronous active-high reset
//   i_load      : capture i_a / i_cnt / i_kind (start of a shift)
//   i_step      : perform one single-bit shift, decrement the counter
//   i_kind      : SHL / SHR / ASR / ROL
//   i_a, i_cnt  : operand and shift amount
//   o_next      : value the work register takes at the next step
//   o_last_out  : bit shifted out by the next step
//   o_done      : the next step is the final one (counter == 1)
module alu_seq_shift
    import alu_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  shift_e           i_kind,
    input  logic [WIDTH-1:0] i_a,
    input  logic [SHW-1:0]   i_cnt,
    output logic [WIDTH-1:0] o_next,
    output logic             o_last_out,
    output logic             o_done
);

    logic [WIDTH-1:0] r_work;
    logic [SHW-1:0]   r_cnt;
    shift_e           r_kind;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_work <= '0;
            r_cnt  <= '0;
            r_kind <= SH_SHL;
        end else if (i_load) begin
            r_work <= i_a;
            r_cnt  <= i_cnt;
            r_kind <= i_kind;
        end else if (i_step) begin
            r_work <= o_next;
            r_cnt  <= r_cnt - SHW'(1);
        end
    end

    always_comb begin
        o_next     = r_work;
        o_last_out = 1'b0;
        case (r_kind)
            SH_SHL: begin
                o_next     = {r_work[WIDTH-2:0], 1'b0};
                o_last_out = r_work[WIDTH-1];
            end
            SH_SHR: begin
                o_next     = {1'b0, r_work[WIDTH-1:1]};
                o_last_out = r_work[0];
            end
            SH_ASR: begin
                o_next     = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
                o_last_out = r_work[0];
            end
            SH_ROL: begin
                o_next     = {r_work[WIDTH-2:0], r_work[WIDTH-1]};
                o_last_out = r_work[WIDTH-1];
            end
            default: ;
        endcase
    end

    assign o_done = (r_cnt == SHW'(1));

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes, a persistent carry register
// for ADC/SBB chains and serial multi-bit shifts.
// Handshake: a transfer happens on either side exactly when valid && ready
// at a rising edge; a presented result (out, flags, err) holds steady until
// its transfer.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (A, B, OPcode)
//   A, B, OPcode        : operands; B[SHW-1:0] is the shift amount
//   out_valid/out_ready : result handshake
//   out, flags, err     : result, {gt,v,n,z,c}, illegal-opcode marker
//   c_flag              : live stored carry
module alu_seq
    import alu_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       OPcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [4:0]       flags,
    output logic             c_flag,
    output logic             err
);

    state_e           r_state, w_state_next;
    logic [WIDTH-1:0] r_out;
    logic [4:0]       r_flags;
    logic             r_cf, r_err, r_out_valid, r_gt;

    logic             w_accept, w_shift_start, w_single_load, w_shift_done;
    logic             w_cin, w_gt, w_c, w_v, w_err, w_cf_we;
    logic [WIDTH:0]   w_add, w_sub;
    logic [WIDTH-1:0] w_res;
    logic [4:0]       w_flags, w_sh_flags;
    logic [WIDTH-1:0] w_sh_next;
    logic             w_sh_last, w_sh_done;

    assign in_ready      = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
    assign w_accept      = in_valid && in_ready;
    assign w_shift_start = w_accept && is_shift_op(OPcode) && (B[SHW-1:0] != '0);
    assign w_single_load = w_accept && !w_shift_start;
    assign w_shift_done  = (r_state == ST_SHIFT) && w_sh_done;

    // Single-cycle result path (also covers shifts by zero).
    always_comb begin
        // ADC and SBB are the odd arithmetic opcodes; only they consume carry.
        w_cin = r_cf & OPcode[0];
        w_add = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, w_cin};
        // Subtract as A + ~B + !cin: carry-out is the inverted borrow, and
        // overflow is carry-into-msb xor carry-out, exact even with cin.
        w_sub = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, ~w_cin};
        w_gt  = (A > B);

        w_res   = '0;
        w_c     = r_cf;
        w_v     = 1'b0;
        w_err   = 1'b0;
        w_cf_we = 1'b0;
        case (OPcode)
            OP_ADD, OP_ADC: begin
                w_res   = w_add[WIDTH-1:0];
                w_c     = w_add[WIDTH];
                w_v     = (A[WIDTH-1] ^ B[WIDTH-1] ^ w_add[WIDTH-1]) ^ w_add[WIDTH];
                w_cf_we = 1'b1;
            end
            OP_SUB, OP_SBB: begin
                w_res   = w_sub[WIDTH-1:0];
                w_c     = ~w_sub[WIDTH];
                w_v     = (A[WIDTH-1] ^ ~B[WIDTH-1] ^ w_sub[WIDTH-1]) ^ w_sub[WIDTH];
                w_cf_we = 1'b1;
            end
            OP_AND: w_res = A & B;
            OP_OR:  w_res = A | B;
            OP_XOR: w_res = A ^ B;
            OP_GT:  w_res = {{(WIDTH-1){1'b0}}, w_gt};
            OP_SHL, OP_SHR, OP_ASR, OP_ROL, OP_CLC: begin
                w_res   = A;
                w_c     = 1'b0;
                w_cf_we = 1'b1;
            end
            default: w_err = 1'b1;
        endcase

        w_flags = '0;
        if (!w_err) begin
            w_flags[F_C]  = w_c;
            w_flags[F_Z]  = (w_res == '0);
            w_flags[F_N]  = w_res[WIDTH-1];
            w_flags[F_V]  = w_v;
            w_flags[F_GT] = w_gt;
        end

        w_sh_flags       = '0;
        w_sh_flags[F_C]  = w_sh_last;
        w_sh_flags[F_Z]  = (w_sh_next == '0);
        w_sh_flags[F_N]  = w_sh_next[WIDTH-1];
        w_sh_flags[F_GT] = r_gt;
    end

    alu_seq_shift #(.WIDTH(WIDTH)) u_shift (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_shift_start),
        .i_step     (r_state == ST_SHIFT),
        .i_kind     (shift_e'(OPcode[1:0])),
        .i_a        (A),
        .i_cnt      (B[SHW-1:0]),
        .o_next     (w_sh_next),
        .o_last_out (w_sh_last),
        .o_done     (w_sh_done)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_shift_start) w_state_next = ST_SHIFT;
            ST_SHIFT: if (w_sh_done)     w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out       <= '0;
            r_flags     <= '0;
            r_cf        <= 1'b0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
            r_gt        <= 1'b0;
        end else if (w_single_load) begin
            r_out       <= w_res;
            r_flags     <= w_flags;
            r_err       <= w_err;
            r_out_valid <= 1'b1;
            if (w_cf_we) r_cf <= w_c;
        end else if (w_shift_start) begin
            // Any previous result retires at this edge (in_ready implies it).
            r_out_valid <= 1'b0;
            r_gt        <= w_gt;
        end else if (w_shift_done) begin
            r_out       <= w_sh_next;
            r_flags     <= w_sh_flags;
            r_err       <= 1'b0;
            r_out_valid <= 1'b1;
            r_cf        <= w_sh_last;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out       = r_out;
    assign flags     = r_flags;
    assign c_flag    = r_cf;
    assign err       = r_err;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  localparam int W    = 8;
  localparam int EW   = W + 7;  // {c_flag_after, err, flags[4:0], out}
  localparam int SMAX = (1 << (W - 1)) - 1;
  localparam int SMIN = -(1 << (W - 1));

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [3:0]   OPcode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic [4:0]   flags;
  logic         c_flag;
  logic         err;

  int checks   = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];
  logic g_rnd_bp  = 1'b0;
  logic model_cf  = 1'b0;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] o;
    logic [4:0]   f;
    logic         e;
    logic         cf;
  } vec_t;

  vec_t vt[22];

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .OPcode    (OPcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .flags     (flags),
    .c_flag    (c_flag),
    .err       (err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not end, got timeout required finish");
    $fatal(1);
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Reference: each op computed from its arithmetic meaning on plain ints.
  function automatic logic [EW-1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic cf);
    int ua, ub, sa, sb, s, cin, r;
    logic c, v, ncf;
    logic [W-1:0] o;
    ua  = int'(a);
    ub  = int'(b);
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    s   = ub % W;
    cin = (op == 4'd1 || op == 4'd3) ? int'(cf) : 0;
    r   = 0;
    c   = cf;
    v   = 1'b0;
    ncf = cf;
    case (op)
      4'd0, 4'd1: begin
        r = ua + ub + cin;
        c = (r >= (1 << W));
        v = (sa + sb + cin > SMAX) || (sa + sb + cin < SMIN);
        ncf = c;
      end
      4'd2, 4'd3: begin
        r = ua - ub - cin;
        c = (ua < ub + cin);
        v = (sa - sb - cin > SMAX) || (sa - sb - cin < SMIN);
        ncf = c;
      end
      4'd4: r = ua & ub;
      4'd5: r = ua | ub;
      4'd6: r = ua ^ ub;
      4'd7: r = (ua > ub) ? 1 : 0;
      4'd8: begin
        r = ua << s;
        c = (s == 0) ? 1'b0 : (((ua >> (W - s)) & 1) != 0);
        ncf = c;
      end
      4'd9: begin
        r = ua >> s;
        c = (s == 0) ? 1'b0 : (((ua >> (s - 1)) & 1) != 0);
        ncf = c;
      end
      4'd10: begin
        r = sa >>> s;
        c = (s == 0) ? 1'b0 : (((ua >> (s - 1)) & 1) != 0);
        ncf = c;
      end
      4'd11: begin
        r = (ua << s) | (ua >> (W - s));
        c = (s == 0) ? 1'b0 : ((r & 1) != 0);
        ncf = c;
      end
      4'd12: begin
        r = ua;
        c = 1'b0;
        ncf = 1'b0;
      end
      default: return {cf, 1'b1, 5'b00000, {W{1'b0}}};
    endcase
    o = r[W-1:0];
    return {ncf, 1'b0, (ua > ub), v, o[W-1], (o == '0), c, o};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  task automatic monitor_loop();
    logic         hold_pend;
    logic [W+5:0] hold_val;
    logic [EW-1:0] e;
    hold_pend = 1'b0;
    hold_val  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", {err, flags, out}, hold_val);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("result_out", out, e[W-1:0]);
            check("result_flags", flags, e[W+4:W]);
            check("result_err", err, e[W+5]);
            check("result_cflag", c_flag, e[W+6]);
          end
        end
        hold_pend = out_valid && !out_ready;
        hold_val  = {err, flags, out};
      end
    end
  endtask

  // ---------------- drivers ----------------
  // Called at posedge+1; returns at posedge+1 after the accept edge with
  // in_valid still high so a following send is back-to-back.
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    A = a;
    B = b;
    OPcode = op;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      if (g_rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (g_rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic push_model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [EW-1:0] e;
    e = model(op, a, b, model_cf);
    model_cf = e[EW-1];
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic fill_table();
    vt[0]  = '{4'd0,  8'hF0, 8'h20, 8'h10, 5'b10001, 1'b0, 1'b1};
    vt[1]  = '{4'd1,  8'h00, 8'h00, 8'h01, 5'b00000, 1'b0, 1'b0};
    vt[2]  = '{4'd2,  8'h10, 8'h20, 8'hF0, 5'b00101, 1'b0, 1'b1};
    vt[3]  = '{4'd3,  8'h05, 8'h01, 8'h03, 5'b10000, 1'b0, 1'b0};
    vt[4]  = '{4'd0,  8'h7F, 8'h01, 8'h80, 5'b11100, 1'b0, 1'b0};
    vt[5]  = '{4'd2,  8'h00, 8'h01, 8'hFF, 5'b00101, 1'b0, 1'b1};
    vt[6]  = '{4'd4,  8'h0F, 8'hF0, 8'h00, 5'b00011, 1'b0, 1'b1};
    vt[7]  = '{4'd5,  8'h0F, 8'hF0, 8'hFF, 5'b00101, 1'b0, 1'b1};
    vt[8]  = '{4'd6,  8'hFF, 8'h0F, 8'hF0, 5'b10101, 1'b0, 1'b1};
    vt[9]  = '{4'd7,  8'h30, 8'h20, 8'h01, 5'b10001, 1'b0, 1'b1};
    vt[10] = '{4'd8,  8'h81, 8'h03, 8'h08, 5'b10000, 1'b0, 1'b0};
    vt[11] = '{4'd11, 8'h81, 8'h01, 8'h03, 5'b10001, 1'b0, 1'b1};
    vt[12] = '{4'd9,  8'h81, 8'h02, 8'h20, 5'b10000, 1'b0, 1'b0};
    vt[13] = '{4'd10, 8'h81, 8'h02, 8'hE0, 5'b10100, 1'b0, 1'b0};
    vt[14] = '{4'd0,  8'hFF, 8'h01, 8'h00, 5'b10011, 1'b0, 1'b1};
    vt[15] = '{4'd14, 8'h33, 8'h11, 8'h00, 5'b00000, 1'b1, 1'b1};
    vt[16] = '{4'd8,  8'h12, 8'h00, 8'h12, 5'b10000, 1'b0, 1'b0};
    vt[17] = '{4'd0,  8'hFF, 8'h01, 8'h00, 5'b10011, 1'b0, 1'b1};
    vt[18] = '{4'd12, 8'h55, 8'hAA, 8'h55, 5'b00000, 1'b0, 1'b0};
    vt[19] = '{4'd2,  8'h00, 8'h01, 8'hFF, 5'b00101, 1'b0, 1'b1};
    vt[20] = '{4'd3,  8'h80, 8'h00, 8'h7F, 5'b11000, 1'b0, 1'b0};
    vt[21] = '{4'd8,  8'h01, 8'hF9, 8'h02, 5'b00000, 1'b0, 1'b0};
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [3:0]   op;
    logic [W-1:0] ra, rb;

    rst = 1'b1;
    in_valid = 1'b0;
    A = '0;
    B = '0;
    OPcode = '0;
    out_ready = 1'b1;
    fill_table();
    fork
      monitor_loop();
    join_none

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out", out, 0);
    check("rst_flags", flags, 0);
    check("rst_cflag", c_flag, 0);
    check("rst_err", err, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Directed vector table, back-to-back.
    for (int i = 0; i < 22; i++) begin
      exp_q.push_back({vt[i].cf, vt[i].e, vt[i].f, vt[i].o});
      send(vt[i].op, vt[i].a, vt[i].b);
    end
    in_valid = 1'b0;
    drain();

    // Shift latency: SHL by 3 accepted at edge k, result at edge k+3.
    exp_q.push_back({1'b0, 1'b0, 5'b10000, 8'h08});
    A = 8'h81;
    B = 8'h03;
    OPcode = 4'd8;
    in_valid = 1'b1;
    @(negedge clk);
    check("shl_ready_before", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("shl_busy_in_ready", in_ready, 0);
      check("shl_busy_out_valid", out_valid, 0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("shl_done_valid", out_valid, 1);
    check("shl_done_out", out, 8'h08);
    @(posedge clk);
    #1;
    drain();

    // Backpressure, then retire + accept in the same cycle.
    out_ready = 1'b0;
    exp_q.push_back({1'b0, 1'b0, 5'b00000, 8'h46});
    send(4'd0, 8'h12, 8'h34);
    exp_q.push_back({1'b0, 1'b0, 5'b10000, 8'h33});
    A = 8'h3C;
    B = 8'h0F;
    OPcode = 4'd6;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out", out, 8'h46);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_next_valid", out_valid, 1);
    check("bp_next_out", out, 8'h33);
    @(posedge clk);
    #1;
    drain();

    // Reset during a shift: nothing is ever presented, carry is cleared.
    exp_q.push_back({1'b1, 1'b0, 5'b10011, 8'h00});
    send(4'd0, 8'hFF, 8'h01);
    in_valid = 1'b0;
    drain();
    A = 8'h0F;
    B = 8'h05;
    OPcode = 4'd8;
    in_valid = 1'b1;
    @(negedge clk);
    check("rs_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rs_out_valid", out_valid, 0);
    check("rs_cflag", c_flag, 0);
    check("rs_in_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rs_no_partial", out_valid, 0);
    end
    @(posedge clk);
    #1;

    // Randomized traffic against the reference model.
    model_cf = 1'b0;
    g_rnd_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      ra = W'($urandom);
      rb = W'($urandom);
      push_model(op, ra, rb);
      send(op, ra, rb);
      if ($urandom_range(0, 7) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    g_rnd_bp = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 8-bit combinational ALU.
- Adds a valid/ready handshake on input and output, a persistent carry flag register for multi-word ADC/SBB chains, and a full Z/N/V/C/GT flag set.
- Multi-bit shifts and rotates run serially, one bit position per cycle, under a small FSM.
- Sits between the operand-fetch stage and writeback in the datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; must be ≥2 and a power of two.
- SHW, $clog2(WIDTH), width of the shift-amount field taken from B[SHW-1:0]; derived, do not override.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands/opcode valid.
- in_ready  out  1  block can accept this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B; B[SHW-1:0] is the shift amount for shift ops.
- OPcode  in  4  operation select.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts result.
- out  out  WIDTH  result.
- flags  out  5  {gt,v,n,z,c} captured with result.
- c_flag  out  1  live stored carry register.
- err  out  1  high with a result whose opcode was illegal.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values: out=0, flags=0, c_flag=0, err=0, out_valid=0, FSM=IDLE. in_ready is 1 after the reset cycle.
- Reset mid-shift or with out_valid pending: the operation and result are discarded. No partial result is ever presented.
- Accept: a transfer occurs when in_valid && in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This allows back-to-back single-cycle ops at full throughput.
- Output hold: out, flags and err stay stable while out_valid && !out_ready.
- Opcodes:
  - 0 ADD: A+B.
  - 1 ADC: A+B+c_flag.
  - 2 SUB: A-B.
  - 3 SBB: A-B-c_flag.
  - 4 AND.
  - 5 OR.
  - 6 XOR.
  - 7 GT: out = zero-extended (A>B unsigned).
  - 8 SHL, 9 SHR (logical), 10 ASR, 11 ROL: shift by s=B[SHW-1:0].
  - 12 CLC: out=A, c_flag cleared.
  - 13-15: illegal.
- Arithmetic uses a WIDTH+1-bit sum. c = carry-out for add, borrow-out (A < B+cin) for sub. v = signed overflow.
- z = (out==0), n = out[WIDTH-1], gt = (A>B unsigned) for every op.
- For logic ops, GT and CLC: c = c_flag (unchanged) and v = 0. CLC reports c=0.
- Shifts: c = last bit shifted out (0 if s==0), v = 0.
- c_flag is written only by ADD/ADC/SUB/SBB/shifts/CLC, at the edge the result is loaded. ADC/SBB read c_flag at their accept edge, so back-to-back chained ops see the previous op's carry.
- Illegal opcode: out=0, flags=0, err=1, c_flag unchanged. Takes one cycle.
- Latency, single-cycle ops (and shifts with s==0): accepted at edge k, out_valid=1 from edge k.
- FSM:
  - IDLE --accept shift op, s≠0--> SHIFT: work=A, cnt=s.
  - SHIFT: each edge shifts work by one bit and decrements cnt. At cnt==1 it loads out/flags, sets out_valid and returns to IDLE.
  - A shift with s accepted at edge k gives out_valid at edge k+s. in_ready=0 throughout SHIFT.
- Simultaneous events: out_ready and a new accept in the same cycle means the old result retires and the new result loads at that edge. Without a new accept, out_valid falls.

Decomposition:
- Package alu_pkg holds: opcode localparams (OP_ADD..OP_CLC), flag bit indices (F_C=0, F_Z=1, F_N=2, F_V=3, F_GT=4), and FSM state encoding.
- Sub-module alu_seq_shift holds the serial shift/rotate datapath (work register, counter, last-out bit, done strobe).
- Single-cycle op decode stays in alu_seq.

Test Plan:
- WIDTH=8: ADD A=0xF0,B=0x20 -> out=0x10, c=1, z=0, c_flag=1. Next ADC A=0x00,B=0x00 -> out=0x01, c=0.
- SUB A=0x10,B=0x20 -> out=0xF0, c=1 (borrow), n=1. SBB A=0x05,B=0x01 -> out=0x03.
- ADD A=0x7F,B=0x01 -> out=0x80, v=1, n=1. AND A=0x0F,B=0xF0 -> out=0x00, z=1, c_flag unchanged.
- SHL A=0x81,B=3 accepted at edge k -> in_ready=0 for edges k..k+2, out_valid at k+3, out=0x08, c=0. ROL A=0x81,B=1 -> out=0x03, c=1.
- Backpressure: out_ready=0 for 4 cycles with in_valid=1 -> in_ready=0 and out stable. out_ready=1 with a new XOR accepted in the same cycle -> XOR result appears next edge, no bubble.
- Illegal OPcode=14 -> err=1, out=0. rst asserted during SHL B=5 at cycle 2 -> next cycle out_valid=0, c_flag=0, in_ready=1.
